// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: word width, reset/NOP
// defaults, next-PC select encoding and an address alignment helper.
package fetch_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam word_t PC_STEP           = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_HOLD   = 2'd3
  } npc_sel_e;

  // Redirect targets are always loaded as word addresses.
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and
// the IF/ID pipeline register outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  stall;
  logic  branch_taken;
  word_t branch_target;
  logic  jump;
  word_t jump_target;
  word_t imem_addr;
  word_t imem_rdata;
  word_t if_id_pc4;
  word_t if_id_instr;
  logic  if_id_valid;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    output imem_addr, if_id_pc4, if_id_instr, if_id_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    input  imem_addr, if_id_pc4, if_id_instr, if_id_valid
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush, otherwise
// captures the fetched word together with its PC+4.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stall,
  input  logic  flush,
  input  word_t pc4_in,
  input  word_t instr_in,
  output word_t pc4,
  output word_t instr,
  output logic  valid
);

  word_t pc4_r;
  word_t instr_r;
  logic  valid_r;

  // Pipeline register update; a flushed slot keeps the PC+4 of the discarded fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc4_r   <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (stall) begin
      pc4_r   <= pc4_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end else if (flush) begin
      pc4_r   <= pc4_in;
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else begin
      pc4_r   <= pc4_in;
      instr_r <= instr_in;
      valid_r <= 1'b1;
    end
  end

  assign pc4   = pc4_r;
  assign instr = instr_r;
  assign valid = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, incrementer and prioritised next-PC
// selection, feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEFAULT,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  word_t    pc_r;
  word_t    pc4_s;
  word_t    next_pc_s;
  npc_sel_e sel_s;
  logic     flush_s;
  word_t    if_id_pc4_s;
  word_t    if_id_instr_s;
  logic     if_id_valid_s;

  assign pc4_s   = pc_r + PC_STEP;
  assign flush_s = ~bus.stall & (bus.jump | bus.branch_taken);

  // Next-PC source priority: stall, then jump, then branch, then sequential.
  always_comb begin
    sel_s = NPC_SEQ;
    if (bus.stall) begin
      sel_s = NPC_HOLD;
    end else if (bus.jump) begin
      sel_s = NPC_JUMP;
    end else if (bus.branch_taken) begin
      sel_s = NPC_BRANCH;
    end else begin
      sel_s = NPC_SEQ;
    end
  end

  // Next-PC mux.
  always_comb begin
    next_pc_s = pc4_s;
    case (sel_s)
      NPC_HOLD:   next_pc_s = pc_r;
      NPC_JUMP:   next_pc_s = align_word(bus.jump_target);
      NPC_BRANCH: next_pc_s = align_word(bus.branch_target);
      NPC_SEQ:    next_pc_s = pc4_s;
      default:    next_pc_s = pc4_s;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (bus.stall),
    .flush    (flush_s),
    .pc4_in   (pc4_s),
    .instr_in (bus.imem_rdata),
    .pc4      (if_id_pc4_s),
    .instr    (if_id_instr_s),
    .valid    (if_id_valid_s)
  );

  assign bus.imem_addr   = pc_r;
  assign bus.if_id_pc4   = if_id_pc4_s;
  assign bus.if_id_instr = if_id_instr_s;
  assign bus.if_id_valid = if_id_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// stall/reset sequences and a randomized run against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h2008_0005;
    else return {16'hA5A5, a[15:0]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the architectural state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_addr;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] a, input logic [31:0] p4,
                               input logic [31:0] ins, input logic v);
    check($sformatf("%s imem_addr", tag), bus.imem_addr, a);
    check($sformatf("%s if_id_pc4", tag), bus.if_id_pc4, p4);
    check($sformatf("%s if_id_instr", tag), bus.if_id_instr, ins);
    check($sformatf("%s if_id_valid", tag), {31'd0, bus.if_id_valid}, {31'd0, v});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    bus.stall = st; bus.branch_taken = br; bus.branch_target = bt;
    bus.jump = jp; bus.jump_target = jt;
    @(posedge clk);
    if (!st) begin
      m_pc4 = m_pc + 32'd4;
      if (jp || br) begin
        m_instr = NOP;
        m_valid = 1'b0;
        m_pc    = jp ? {jt[31:2], 2'b00} : {bt[31:2], 2'b00};
      end else begin
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.jump = 1'b0; bus.jump_target = 32'h0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4,   32'h4,   32'hA5A5_0000, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h8,   32'h8,   32'hA5A5_0004, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC,   32'hC,   32'h2008_0005, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h10,  32'h10,  32'hA5A5_000C, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   32'h40,  32'h14,  NOP,           1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h44,  32'h44,  32'hA5A5_0040, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h44,  32'h44,  32'hA5A5_0040, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h200, 1'b1, 32'h103, 32'h100, 32'h48,  NOP,           1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h100, 32'h48,  NOP,           1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 32'h104, 32'hA5A5_0100, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h108, NOP, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0,   32'hA5A5_FFFC, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4,   32'h4,   32'hA5A5_0000, 1'b1};

    // Reset state, checked both before and after clock edges under reset
    #3;
    check_outputs("reset_async", 32'h0, 32'h0, NOP, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held", 32'h0, 32'h0, NOP, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].st, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc4,
                    vecs[i].e_instr, vecs[i].e_valid);
    end

    // Stall holding a branch at PC=20, then stall drops with branch still high
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    check_outputs("to20", 32'h20, 32'h8, NOP, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_outputs("at20", 32'h24, 32'h24, 32'hA5A5_0020, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      check_outputs($sformatf("stall_br%0d", k), 32'h20, 32'h28, NOP, 1'b0);
    end
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    check_outputs("stall_release", 32'h80, 32'h24, NOP, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_outputs("after_branch", 32'h84, 32'h84, 32'hA5A5_0080, 1'b1);

    // Reset asserted mid-cycle with a stall and jump pending
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h300;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("midreset", 32'h0, 32'h0, NOP, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("midreset_edge", 32'h0, 32'h0, NOP, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_outputs("post_reset", 32'h4, 32'h4, 32'hA5A5_0000, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_outputs("post_reset2", 32'h8, 32'h8, 32'hA5A5_0004, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 6) == 0, $urandom);
      check_outputs($sformatf("rand%0d", n), m_pc, m_pc4, m_instr, m_valid);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
